misr_signature_compactor: RTL and testbench

Signature compaction stage directly downstream of the circuit-under-test outputs in the fault-simulation bench. Each applied test vector's response word is folded into a multiple-input signature register (MISR). After a programmed number of vectors, the final signature is compared against a golden signature, producing one pass/fail verdict per fault-injection run. One instance sits on the faulty-net output bus; an optional second instance sits on the good-circuit bus.

---
 rtl/misr_pkg.sv | 21 ++
 rtl/misr_signature_compactor_core.sv | 26 ++
 rtl/misr_signature_compactor.sv | 70 +++++++
 tb/tb_misr_signature_compactor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/misr_pkg.sv
// misr_pkg: shared MISR state encoding, feedback polynomials and the signature-step function
package misr_pkg;
  typedef enum logic [1:0] {IDLE, COMPACT, DONE} state_e;
  localparam int MAX_W = 32;
  localparam logic [7:0]  POLY_W8  = 8'h1D;
  localparam logic [8:0]  POLY_W9  = 9'h011;
  localparam logic [9:0]  POLY_W10 = 10'h009;
  localparam logic [10:0] POLY_W11 = 11'h005;
  localparam logic [11:0] POLY_W12 = 12'h053;
  localparam logic [12:0] POLY_W13 = 13'h01B;
  localparam logic [13:0] POLY_W14 = 14'h002B;
  localparam logic [14:0] POLY_W15 = 15'h0003;
  localparam logic [15:0] POLY_W16 = 16'h002D;
  // Works on a MAX_W container; w selects the live width, bits above it are cleared.
  function automatic logic [MAX_W-1:0] misr_next(input logic [MAX_W-1:0] sig, input logic [MAX_W-1:0] d,
                                                 input logic [MAX_W-1:0] poly, input int unsigned w);
    logic [MAX_W-1:0] m;
    m = (MAX_W'(1) << w) - MAX_W'(1);
    return ({sig[MAX_W-2:0], 1'b0} ^ (sig[5'(w - 1)] ? poly : '0) ^ d) & m;
  endfunction
endpackage

// File: rtl/misr_signature_compactor_core.sv
// misr_core: signature register with seed load and update enable; exposes the next value for the verdict
module misr_core
  import misr_pkg::*;
#(
  parameter int             WIDTH = 14,
  parameter logic [WIDTH-1:0] POLY = POLY_W14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sig_o,
  output logic [WIDTH-1:0] nxt_o
);
  logic [WIDTH-1:0] sig_q, sig_d;
  always_comb begin
    nxt_o = WIDTH'(misr_next(MAX_W'(sig_q), MAX_W'(data_i), MAX_W'(POLY), WIDTH));
    sig_d = load_i ? seed_i : en_i ? nxt_o : sig_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  assign sig_o = sig_q;
endmodule

// File: rtl/misr_signature_compactor.sv
// misr_signature_compactor: folds TEST_COUNT response words into a MISR and compares with a golden signature.
// Define MISR_X_MASK_EN to add data_mask_i, whose set bits are forced to 0 before compaction.
module misr_signature_compactor
  import misr_pkg::*;
#(
  parameter int               WIDTH      = 14,
  parameter int               TEST_COUNT = 148,
  parameter logic [WIDTH-1:0] POLY       = POLY_W14,
  parameter logic [WIDTH-1:0] SEED       = '0,
  localparam int              CW         = $clog2(TEST_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic [WIDTH-1:0] golden_i,
`ifdef MISR_X_MASK_EN
  input  logic [WIDTH-1:0] data_mask_i,
`endif
  output logic [WIDTH-1:0] signature_o,
  output logic [CW-1:0]    count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o
);
  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pass_q, pass_d;
  logic             start_ok, acc, last;
  logic [WIDTH-1:0] d, nxt;
`ifdef MISR_X_MASK_EN
  assign d = data_in_i & ~data_mask_i;
`else
  assign d = data_in_i;
`endif
  misr_core #(.WIDTH(WIDTH), .POLY(POLY)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (start_ok),
    .seed_i (SEED),
    .en_i   (acc),
    .data_i (d),
    .sig_o  (signature_o),
    .nxt_o  (nxt)
  );
  // start is only honoured outside a run; an in-flight run always completes
  always_comb begin
    start_ok = start_i && (state_q != COMPACT);
    acc      = (state_q == COMPACT) && valid_i;
    last     = acc && (count_q == CW'(TEST_COUNT - 1));
    state_d  = start_ok ? COMPACT : last ? DONE : state_q;
    count_d  = start_ok ? '0 : acc ? count_q + CW'(1) : count_q;
    pass_d   = start_ok ? 1'b0 : last ? (nxt == golden_i) : pass_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pass_q  <= pass_d;
    end
  assign count_o = count_q;
  assign busy_o  = (state_q == COMPACT);
  assign done_o  = (state_q == DONE);
  assign pass_o  = pass_q;
endmodule

// File: tb/tb_misr_signature_compactor.sv
// tb_misr_signature_compactor: randomized and directed checks against a polynomial-arithmetic reference model
module tb_misr_signature_compactor;
  localparam int          TC   = 15;
  localparam logic [13:0] POLY = 14'h002B;
  localparam logic [13:0] SEED = 14'h0000;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        start = 1'b0, valid = 1'b0;
  logic [13:0] din = '0, golden = '0, sig;
  logic [3:0]  cnt;
  logic        busy, done, pass;
  logic        start1 = 1'b0, valid1 = 1'b0;
  logic [13:0] din1 = '0, golden1 = '0, sig1;
  logic [0:0]  cnt1;
  logic        busy1, done1, pass1;
`ifdef MISR_X_MASK_EN
  logic [13:0] mask = '0, mask1 = '0;
`endif
  logic [13:0] m_sig;
  int          m_cnt;
  bit          m_busy, m_done, m_pass;
  int          n_chk = 0, n_fail = 0;
  logic [13:0] vec [TC];

  misr_signature_compactor #(.WIDTH(14), .TEST_COUNT(TC), .POLY(POLY), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .valid_i(valid), .data_in_i(din), .golden_i(golden),
`ifdef MISR_X_MASK_EN
    .data_mask_i(mask),
`endif
    .signature_o(sig), .count_o(cnt), .busy_o(busy), .done_o(done), .pass_o(pass));

  misr_signature_compactor #(.WIDTH(14), .TEST_COUNT(1), .POLY(POLY), .SEED(SEED)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .valid_i(valid1), .data_in_i(din1), .golden_i(golden1),
`ifdef MISR_X_MASK_EN
    .data_mask_i(mask1),
`endif
    .signature_o(sig1), .count_o(cnt1), .busy_o(busy1), .done_o(done1), .pass_o(pass1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Signature as a GF(2) polynomial: multiply by x, reduce modulo x^14+POLY, then add the response word.
  function automatic logic [13:0] fold(input logic [13:0] s, input logic [13:0] d);
    logic [14:0] p;
    p = {s, 1'b0};
    if (p[14]) p = p ^ {1'b1, POLY};
    return p[13:0] ^ d;
  endfunction

  function automatic logic [13:0] eff(input logic [13:0] d);
`ifdef MISR_X_MASK_EN
    return d & ~mask;
`else
    return d;
`endif
  endfunction

  task automatic mreset();
    m_sig = '0; m_cnt = 0; m_busy = 0; m_done = 0; m_pass = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sig"}, sig, m_sig);
    check({tag, ".count"}, cnt, m_cnt);
    check({tag, ".busy"}, busy, m_busy);
    check({tag, ".done"}, done, m_done);
    check({tag, ".pass"}, pass, m_pass);
  endtask

  task automatic step();
    logic [13:0] d, g;
    bit s, v;
    d = eff(din); g = golden; s = start; v = valid;
    @(posedge clk); #1;
    if (s && !m_busy) begin
      m_sig = SEED; m_cnt = 0; m_pass = 0; m_busy = 1; m_done = 0;
    end else if (m_busy && v) begin
      m_sig = fold(m_sig, d);
      m_cnt++;
      if (m_cnt == TC) begin m_busy = 0; m_done = 1; m_pass = (m_sig == g); end
    end
    check_all("step");
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      valid = 1; din = 14'($urandom); step();
    end
    valid = 0;
  endtask

  task automatic run(input bit gaps, input bit mid_start, output int cyc, output int gtot, output logic [13:0] s3);
    logic [13:0] e;
    e = SEED;
    for (int i = 0; i < TC; i++) e = fold(e, eff(vec[i]));
    golden = $urandom_range(1) ? e : e ^ 14'h0001;
    start = 1; valid = 0; step(); start = 0;
    cyc = 0; gtot = 0; s3 = '0;
    for (int i = 0; i < TC; i++) begin
      if (gaps)
        for (int g = int'($urandom_range(3)); g > 0; g--) begin
          valid = 0; din = 14'($urandom); step(); cyc++; gtot++;
        end
      valid = 1; din = vec[i]; start = mid_start && (i == 4); step(); cyc++;
      start = 0; valid = 0;
      if (i == 2) s3 = sig;
    end
    check("run.done", done, 1);
    check("run.count", cnt, TC);
    check("run.pass", pass, golden == e);
  endtask

  initial begin
    int          ca, cb, ga, gb;
    logic [13:0] sa, sb;
    mreset();
    #1 rst_n = 0;
    #2 check_all("reset");
    #5 rst_n = 1;
    valid = 1; din = 14'h1111; step();
    valid = 0;
    for (int k = 0; k < 2; k++) begin
      golden = k == 0 ? 14'h002B : 14'h002A;
      start = 1; step(); start = 0;
      valid = 1; din = 14'h0001; step();
      din = 14'h0000;
      for (int i = 0; i < 13; i++) step();
      check("dir.sig14", sig, 14'h2000);
      step(); valid = 0;
      check("dir.sig15", sig, 14'h002B);
      check("dir.pass", pass, k == 0);
      valid = 1; din = 14'h3FFF; step(); step(); valid = 0;
    end
    for (int i = 0; i < TC; i++) vec[i] = 14'($urandom);
    run(0, 0, ca, ga, sa);
    run(1, 0, cb, gb, sb);
    check("gap.s3", sb, sa);
    check("gap.cycles", cb, ca + gb);
    run(0, 1, ca, ga, sa);
    start = 1; valid = 1; din = 14'($urandom); step(); start = 0; valid = 0;
    check("rs.count", cnt, 0);
    check("rs.sig", sig, SEED);
    check("rs.busy", busy, 1);
    feed(TC);
    check("rs.done", done, 1);
    start = 1; step(); start = 0;
    feed(6);
    valid = 1; din = 14'($urandom);
    #3 rst_n = 0;
    #1 mreset();
    check_all("abort");
    check("abort.busy", busy, 0);
    #2 rst_n = 1; valid = 0;
    for (int i = 0; i < TC; i++) vec[i] = 14'($urandom);
    run(0, 0, ca, ga, sa);
`ifdef MISR_X_MASK_EN
    mask = 14'h3FFF; golden = 14'h0000;
    start = 1; step(); start = 0;
    feed(TC);
    check("mask.sig", sig, 14'h0000);
    check("mask.pass", pass, 1);
    mask = '0;
`endif
    for (int k = 0; k < 2; k++) begin
      start1 = 1; @(posedge clk); #1 start1 = 0;
      check("tc1.busy", busy1, 1);
      check("tc1.sig0", sig1, SEED);
      valid1 = 1; din1 = 14'h1234; golden1 = k == 0 ? 14'h1234 : 14'h1235;
      @(posedge clk); #1 valid1 = 0;
      check("tc1.done", done1, 1);
      check("tc1.sig", sig1, 14'h1234);
      check("tc1.count", cnt1, 1);
      check("tc1.pass", pass1, k == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
